cordic_phase_diff: RTL and testbench

//  Upstream stage of phase2speed. Takes I/Q samples from the Hilbert filter and computes the

---
 rtl/hilbert_pkg.sv | 48 ++++
 rtl/cordic_atan_lut.sv | 21 ++
 rtl/cordic_phase_diff.sv | 155 +++++++++++++++
 tb/tb_cordic_phase_diff.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/hilbert_pkg.sv
`default_nettype none
// ============================================================================
// Package     : hilbert_pkg
// Description : Shared constants, FSM state encoding and arctangent table
//               for the CORDIC phase-difference stage (9Q10 radians).
// Revision    : 1.0 - initial release
// ============================================================================
package hilbert_pkg;

    localparam int PHASE_W    = 19;
    localparam int PHASE_FRAC = 10;
    localparam int Z_W        = 20;
    localparam int ATAN_W     = 12;
    localparam int ATAN_N     = 12;

    localparam int PI_Q10     = 3217;
    localparam int TWO_PI_Q10 = 6434;

    localparam logic signed [Z_W-1:0] PI_Z      = 20'sd3217;
    localparam logic signed [Z_W-1:0] NEG_PI_Z  = -20'sd3217;
    localparam logic signed [Z_W-1:0] TWO_PI_Z  = 20'sd6434;

    // round(atan(2^-k) * 1024), element k at index k
    localparam logic [ATAN_N-1:0][ATAN_W-1:0] ATAN_Q10 = {
        12'd1,   12'd1,   12'd2,   12'd4,
        12'd8,   12'd16,  12'd32,  12'd64,
        12'd127, 12'd251, 12'd475, 12'd804
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PREROT = 2'd1,
        ST_ITER   = 2'd2,
        ST_DIFF   = 2'd3
    } state_t;

    // Single +/-2*pi correction; callers guarantee the input is within 3*pi.
    function automatic logic signed [Z_W-1:0] wrap_pi(input logic signed [Z_W-1:0] v);
        if (v > PI_Z)
            return v - TWO_PI_Z;
        else if (v < NEG_PI_Z)
            return v + TWO_PI_Z;
        else
            return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_atan_lut.sv
`default_nettype none
// ============================================================================
// Module      : cordic_atan_lut
// Description : Combinational ROM, iteration index -> atan(2^-k) in 9Q10.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_atan_lut
    import hilbert_pkg::*;
(
    input  logic [3:0]               k,
    output logic signed [ATAN_W-1:0] atan
);

    always_comb begin
        atan = '0;
        if (k < 4'(ATAN_N))
            atan = ATAN_Q10[k];
    end

endmodule
`default_nettype wire

// File: rtl/cordic_phase_diff.sv
`default_nettype none
// ============================================================================
// Module      : cordic_phase_diff
// Description : Iterative vectoring CORDIC producing the wrapped phase
//               difference of consecutive I/Q samples (9Q10) with a strobe.
//               Optional magnitude port enabled by defining CORDIC_MAG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_phase_diff
    import hilbert_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int ITERS = 11,
    parameter int GUARD = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic signed [IN_W-1:0]    in_i,
    input  logic signed [IN_W-1:0]    in_q,
    output logic                      in_ready,
    output logic signed [PHASE_W-1:0] phase,
    output logic                      sample
`ifdef CORDIC_MAG_EN
    ,
    output logic [IN_W+GUARD-1:0]     mag
`endif
);

    localparam int XW = IN_W + GUARD;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_k;
    logic signed [XW-1:0]    r_x;
    logic signed [XW-1:0]    r_y;
    logic signed [Z_W-1:0]   r_z;
    logic signed [Z_W-1:0]   r_prev_z;
    logic                    r_primed;
    logic                    r_zero;

    logic signed [XW-1:0]      w_xs;
    logic signed [XW-1:0]      w_ys;
    logic signed [ATAN_W-1:0]  w_atan;
    logic signed [Z_W-1:0]     w_atan_z;
    logic signed [Z_W-1:0]     w_z_fin;
    logic signed [Z_W-1:0]     w_d;
    logic signed [PHASE_W-1:0] w_d_wrap;

    cordic_atan_lut u_atan_lut (
        .k    (r_k),
        .atan (w_atan)
    );

    always_ff @(posedge clock) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    w_state_nxt = ST_PREROT;
            end
            ST_PREROT: w_state_nxt = ST_ITER;
            ST_ITER: begin
                if (r_k == 4'(ITERS - 1))
                    w_state_nxt = ST_DIFF;
            end
            ST_DIFF:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_xs     = r_x >>> r_k;
        w_ys     = r_y >>> r_k;
        w_atan_z = Z_W'(w_atan);
        // An all-zero vector has no defined angle; treat it as 0 rad.
        w_z_fin  = r_zero ? '0 : wrap_pi(r_z);
        w_d      = w_z_fin - r_prev_z;
        w_d_wrap = PHASE_W'(wrap_pi(w_d));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_k      <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_z      <= '0;
            r_prev_z <= '0;
            r_primed <= 1'b0;
            r_zero   <= 1'b0;
            phase    <= '0;
            sample   <= 1'b0;
`ifdef CORDIC_MAG_EN
            mag      <= '0;
`endif
        end else begin
            sample <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_x    <= {{GUARD{in_i[IN_W-1]}}, in_i};
                        r_y    <= {{GUARD{in_q[IN_W-1]}}, in_q};
                        r_zero <= (in_i == '0) && (in_q == '0);
                        r_k    <= '0;
                    end
                end
                ST_PREROT: begin
                    // Fold left half-plane into the right so the iterations converge.
                    if (r_x[XW-1]) begin
                        r_x <= -r_x;
                        r_y <= -r_y;
                        r_z <= r_y[XW-1] ? NEG_PI_Z : PI_Z;
                    end else begin
                        r_z <= '0;
                    end
                end
                ST_ITER: begin
                    if (!r_y[XW-1]) begin
                        r_x <= r_x + w_ys;
                        r_y <= r_y - w_xs;
                        r_z <= r_z + w_atan_z;
                    end else begin
                        r_x <= r_x - w_ys;
                        r_y <= r_y + w_xs;
                        r_z <= r_z - w_atan_z;
                    end
                    r_k <= r_k + 4'd1;
                end
                ST_DIFF: begin
                    r_prev_z <= w_z_fin;
                    r_primed <= 1'b1;
                    if (r_primed) begin
                        phase  <= w_d_wrap;
                        sample <= 1'b1;
                    end
`ifdef CORDIC_MAG_EN
                    mag <= r_x;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cordic_phase_diff.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_phase_diff
// Description : Table-driven, scoreboard-checked bench for cordic_phase_diff.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_phase_diff;

    localparam int IN_W  = 16;
    localparam int ITERS = 11;
    localparam int GUARD = 2;
    localparam int LAT   = ITERS + 2;
    localparam int NVEC  = 15;

    typedef struct {
        int i;
        int q;
        int exp;
        int tol;
    } vec_t;

    typedef struct {
        int exp;
        int tol;
        int acc;
    } sb_t;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic                   in_valid = 1'b0;
    logic signed [IN_W-1:0] in_i = '0;
    logic signed [IN_W-1:0] in_q = '0;
    logic                   in_ready;
    logic signed [18:0]     phase;
    logic                   sample;
`ifdef CORDIC_MAG_EN
    logic [IN_W+GUARD-1:0]  mag;
`endif

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_strobe = 0;
    bit   primed = 0;
    sb_t  sb[$];
    vec_t vecs[NVEC];

    cordic_phase_diff #(.IN_W(IN_W), .ITERS(ITERS), .GUARD(GUARD)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_i     (in_i),
        .in_q     (in_q),
        .in_ready (in_ready),
        .phase    (phase),
        .sample   (sample)
`ifdef CORDIC_MAG_EN
        ,
        .mag      (mag)
`endif
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp, input int tol);
        int diff;
        diff = act - exp;
        if (diff < 0) diff = -diff;
        total++;
        if (diff > tol) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (+/-%0d) at cycle %0d", name, act, exp, tol, cyc);
        end
    endtask

    task automatic monitor();
        bit  s_d;
        sb_t e;
        s_d = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                s_d = 1'b0;
            end else begin
                if (sample) begin
                    n_strobe++;
                    check("no_back_to_back", int'(s_d), 0, 0);
                    if (sb.size() == 0) begin
                        check("unexpected_strobe", 1, 0, 0);
                    end else begin
                        e = sb.pop_front();
                        check("phase", int'(phase), e.exp, e.tol);
                        check("latency", cyc - e.acc, LAT, 0);
                    end
                end
                s_d = sample;
            end
        end
    endtask

    // Waits for IDLE, presents one vector for one edge, queues its expectation.
    task automatic send(input int i, input int q, input int exp, input int tol);
        int w;
        w = 0;
        @(negedge clock);
        while (!in_ready && w < 40) begin
            @(negedge clock);
            w++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1, 0);
            return;
        end
        in_valid = 1'b1;
        in_i     = IN_W'(i);
        in_q     = IN_W'(q);
        if (primed) sb.push_back('{exp: exp, tol: tol, acc: cyc + 1});
        primed = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 60) begin
            @(negedge clock);
            w++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0, 0);
        @(negedge clock);
    endtask

    initial begin
        int s0;
        int t0;

        // {I, Q, expected wrapped difference, tolerance}; entry 0 only primes.
        vecs[0]  = '{1000,      0,     0, 0};
        vecs[1]  = '{   0,   1000,  1608, 3};
        vecs[2]  = '{ 700,   -700, -2412, 3};
        vecs[3]  = '{ 700,   -700,     0, 2};
        vecs[4]  = '{ 700,   -700,     0, 2};
        vecs[5]  = '{ 700,   -700,     0, 2};
        vecs[6]  = '{ 700,   -700,     0, 2};
        vecs[7]  = '{-985,    174, -2592, 4};
        vecs[8]  = '{-985,   -174,   358, 3};
        vecs[9]  = '{1000,      0,  3038, 4};
        vecs[10] = '{   0,      0,     0, 3};
        vecs[11] = '{-20000, -15000, -2558, 4};
        vecs[12] = '{32767, -32768,  1754, 4};
        vecs[13] = '{-32768,     0, -2413, 4};
        vecs[14] = '{12000,   9000, -2558, 4};

        fork
            monitor();
        join_none

        repeat (3) @(negedge clock);
        check("reset_in_ready", int'(in_ready), 1, 0);
        check("reset_sample", int'(sample), 0, 0);
        check("reset_phase", int'(phase), 0, 0);
        reset = 1'b0;

        // Table: priming, quadrant steps, constant input, wrap, zero vector, full scale.
        for (int n = 0; n < NVEC; n++)
            send(vecs[n].i, vecs[n].q, vecs[n].exp, vecs[n].tol);
        drain();
        check("strobes_after_table", n_strobe, NVEC - 1, 0);

        // in_valid held high: only IDLE-cycle samples accepted, 14-cycle cadence.
        @(negedge clock);
        check("idle_before_hold", int'(in_ready), 1, 0);
        in_valid = 1'b1;
        in_i     = 16'sd300;
        in_q     = 16'sd400;
        t0 = cyc + 1;
        for (int j = 0; j < 56; j++) begin
            if (j % 14 == 0) begin
                sb.push_back('{exp: (j == 0) ? 291 : 0, tol: (j == 0) ? 4 : 2, acc: t0 + j});
            end
            @(negedge clock);
            check("in_ready_hold", int'(in_ready), (j % 14 == 13) ? 1 : 0, 0);
        end
        in_valid = 1'b0;
        drain();
        check("strobes_after_hold", n_strobe, NVEC - 1 + 4, 0);

        // Reset mid-ITER: pending result discarded, then re-prime.
        send(500, 500, 0, 0);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        sb.delete();
        primed = 1'b0;
        s0 = n_strobe;
        repeat (2) @(negedge clock);
        check("abort_in_ready", int'(in_ready), 1, 0);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        check("no_strobe_after_abort", n_strobe, s0, 0);
        send(1000, 0, 0, 0);
        send(0, 1000, 1608, 3);
        drain();
        check("reprime_strobes", n_strobe, s0 + 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
